// File: rtl/pc_fetch_stage_if.sv
// Fetch-stage bus: PC / PC+4 adder loop, imem handshake, hazard controls and IF/ID outputs.
// The fetch stage takes the master side; the surrounding pipeline (adder, imem, hazard unit,
// branch resolution, decode) connects to the slave side.
interface pc_fetch_stage_if;
    // PC loop with the external PC+4 adder
    logic [31:0] pc_out;
    logic [31:0] pc_plus4_in;

    // Single-outstanding instruction memory handshake
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    // Hazard unit and downstream branch/jump resolution
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    // IF/ID pipeline register contents
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc_plus4;
    logic [31:0] ifid_instr;

    // Misaligned redirect indication (only active when alignment checking is built in)
    logic        misalign_err;

    modport master (
        output pc_out,
        input  pc_plus4_in,
        output imem_req,
        input  imem_ready,
        input  imem_rdata,
        input  stall,
        input  redirect_valid,
        input  redirect_pc,
        output ifid_valid,
        output ifid_pc,
        output ifid_pc_plus4,
        output ifid_instr,
        output misalign_err
    );

    modport slave (
        input  pc_out,
        output pc_plus4_in,
        input  imem_req,
        output imem_ready,
        output imem_rdata,
        output stall,
        output redirect_valid,
        output redirect_pc,
        input  ifid_valid,
        input  ifid_pc,
        input  ifid_pc_plus4,
        input  ifid_instr,
        input  misalign_err
    );
endinterface

// File: rtl/pc_fetch_stage.sv
// PC register, single-outstanding imem fetch control and IF/ID register (optional FETCH_ALIGN_CHK_EN).
// Latency: zero-wait fetch lands in IF/ID on the transfer edge; 1 instr/cycle sustained.
// Backpressure: stall parks a completed fetch in a one-entry skid (HELD, no request) until release.
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    pc_fetch_stage_if.master  bus
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_HELD  = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] instr;
    } fetch_ent_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic        imem_req_q;
    logic        ifid_valid_q;
    fetch_ent_t  ifid_q;
    // Skid holds the one fetch that completed under stall; it is occupied exactly while in HELD.
    fetch_ent_t  skid_q;
    logic        misalign_q;

    logic        xfer;
    logic [31:0] redir_tgt;
    logic        redir_misaligned;
    fetch_ent_t  fetched;

    // Transfer qualification, the word just returned, and the redirect target after optional alignment
    always_comb begin
        xfer             = imem_req_q & bus.imem_ready;
        fetched.pc       = pc_q;
        fetched.pc_plus4 = bus.pc_plus4_in;
        fetched.instr    = bus.imem_rdata;
`ifdef FETCH_ALIGN_CHK_EN
        redir_misaligned = (bus.redirect_pc[1:0] != 2'b00);
        redir_tgt        = {bus.redirect_pc[31:2], 2'b00};
`else
        redir_misaligned = 1'b0;
        redir_tgt        = bus.redirect_pc;
`endif
    end

    // Fetch FSM: reset, then redirect, then per-state sequencing; all outputs registered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_BOOT;
            pc_q         <= RESET_PC;
            imem_req_q   <= 1'b0;
            ifid_valid_q <= 1'b0;
            ifid_q       <= '0;
            skid_q       <= '0;
            misalign_q   <= 1'b0;
        end else if (bus.redirect_valid) begin
            // Flush: the IF/ID entry, any parked skid entry and any same-cycle return are all wrong-path
            state_q      <= S_FETCH;
            pc_q         <= redir_tgt;
            imem_req_q   <= 1'b1;
            ifid_valid_q <= 1'b0;
            skid_q       <= '0;
            misalign_q   <= redir_misaligned;
        end else begin
            misalign_q <= 1'b0;
            case (state_q)
                S_BOOT: begin
                    state_q    <= S_FETCH;
                    imem_req_q <= 1'b1;
                end

                S_FETCH: begin
                    if (xfer && !bus.stall) begin
                        ifid_valid_q <= 1'b1;
                        ifid_q       <= fetched;
                        pc_q         <= bus.pc_plus4_in;
                    end else if (xfer) begin
                        // Decode is stalled: park the word and stop requesting until release
                        skid_q     <= fetched;
                        state_q    <= S_HELD;
                        imem_req_q <= 1'b0;
                    end else if (!bus.stall) begin
                        // Nothing arrived and decode consumed IF/ID: insert a bubble
                        ifid_valid_q <= 1'b0;
                    end
                end

                S_HELD: begin
                    if (!bus.stall) begin
                        ifid_valid_q <= 1'b1;
                        ifid_q       <= skid_q;
                        pc_q         <= skid_q.pc_plus4;
                        state_q      <= S_FETCH;
                        imem_req_q   <= 1'b1;
                    end
                end

                default: begin
                    state_q    <= S_BOOT;
                    imem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc_out        = pc_q;
    assign bus.imem_req      = imem_req_q;
    assign bus.ifid_valid    = ifid_valid_q;
    assign bus.ifid_pc       = ifid_q.pc;
    assign bus.ifid_pc_plus4 = ifid_q.pc_plus4;
    assign bus.ifid_instr    = ifid_q.instr;

`ifdef FETCH_ALIGN_CHK_EN
    assign bus.misalign_err  = misalign_q;
`else
    // Without alignment checking the flag never fires; the register is kept at zero
    logic misalign_unused;
    assign misalign_unused   = misalign_q;
    assign bus.misalign_err  = 1'b0;
`endif

endmodule
